serial_tx_frame: RTL

//  Parametrised successor to the fixed 5-byte Serial transmitter. On a START rising

---
 rtl/serial_tx_frame_if.sv | 14 +
 rtl/serial_tx_frame.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_tx_frame_if.sv
// Handshake bundle between the frame transmitter and its requester:
// the START request, the payload, and the serial line with its status.
interface serial_tx_frame_if #(
  parameter int NBYTES = 5
);
  logic                  START;
  logic [8*NBYTES-1:0]   BUFFER;
  logic                  SIGNAL;
  logic                  BUSY;
  logic                  END;

  modport master (output START, BUFFER, input  SIGNAL, BUSY, END);
  modport slave  (input  START, BUFFER, output SIGNAL, BUSY, END);
endinterface

// File: rtl/serial_tx_frame.sv
// Multi-byte UART frame transmitter: MSB byte first, 8 data bits LSB-first,
// optional idle gap between bytes. Define PARITY_EN to add a parity bit per frame.
module serial_tx_frame #(
  parameter int NBYTES       = 5,
  parameter int CLKS_PER_BIT = 868,
  parameter int GAP_BITS     = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  serial_tx_frame_if.slave  bus
);

  localparam int BW  = $clog2(CLKS_PER_BIT);
  localparam int BYW = $clog2(NBYTES + 1);
  localparam int GW  = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int SW  = 8 * NBYTES;

  localparam logic [BW-1:0]  LAST_BAUD = BW'(CLKS_PER_BIT - 1);
  localparam logic [BYW-1:0] LAST_BYTE = BYW'(NBYTES - 1);
  localparam logic [GW-1:0]  LAST_GAP  = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  if (NBYTES < 1 || NBYTES > 64 || CLKS_PER_BIT < 2 ||
      GAP_BITS < 0 || GAP_BITS > 15 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_err
    $error("serial_tx_frame: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    STARTB,
    DATA,
`ifdef PARITY_EN
    PARITY,
`endif
    STOP,
    GAP,
    DONE
  } state_t;

  state_t          state, state_d;
  logic [BW-1:0]   baud, baud_d;
  logic [2:0]      bit_idx, bit_idx_d;
  logic [BYW-1:0]  byte_idx, byte_idx_d;
  logic [GW-1:0]   gap_cnt, gap_cnt_d;
  logic [SW-1:0]   shreg, shreg_d;
  logic            start_q;
  logic            sig_q, sig_d;
  logic            start_edge;
  logic            tick;
  logic [7:0]      cur_byte_d;

  assign start_edge = bus.START & ~start_q;
  assign tick       = (baud == LAST_BAUD);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      start_q  <= 1'b0;
      sig_q    <= 1'b1;
    end else begin
      state    <= state_d;
      baud     <= baud_d;
      bit_idx  <= bit_idx_d;
      byte_idx <= byte_idx_d;
      gap_cnt  <= gap_cnt_d;
      shreg    <= shreg_d;
      start_q  <= bus.START;
      sig_q    <= sig_d;
    end
  end

  always_comb begin
    state_d    = state;
    baud_d     = baud;
    bit_idx_d  = bit_idx;
    byte_idx_d = byte_idx;
    gap_cnt_d  = gap_cnt;
    shreg_d    = shreg;

    // Baud counter free-runs inside any bit state and wraps on each bit boundary.
    if (state != IDLE && state != DONE)
      baud_d = tick ? '0 : baud + 1'b1;

    case (state)
      IDLE: begin
        if (start_edge) begin
          state_d    = STARTB;
          shreg_d    = bus.BUFFER;
          baud_d     = '0;
          bit_idx_d  = '0;
          byte_idx_d = '0;
          gap_cnt_d  = '0;
        end
      end
      STARTB: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        if (tick) begin
          if (byte_idx == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            byte_idx_d = byte_idx + 1'b1;
            shreg_d    = shreg << 8;
            gap_cnt_d  = '0;
            state_d    = (GAP_BITS > 0) ? GAP : STARTB;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt == LAST_GAP) state_d = STARTB;
          else                     gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        baud_d  = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // The line is registered from the next-state view so the start bit appears
  // in the very cycle the START edge is accepted.
  always_comb begin
    cur_byte_d = shreg_d[SW-1 -: 8];
    sig_d      = 1'b1;
    case (state_d)
      STARTB: sig_d = 1'b0;
      DATA:   sig_d = cur_byte_d[bit_idx_d];
`ifdef PARITY_EN
      PARITY: sig_d = (^cur_byte_d) ^ PARITY_ODD[0];
`endif
      default: sig_d = 1'b1;
    endcase
  end

  assign bus.SIGNAL = sig_q;
  assign bus.BUSY   = (state != IDLE) && (state != DONE);
  assign bus.END    = (state == DONE);

endmodule
